// File: rtl/minmax_scanner_pkg.sv
// Shared types and compare helper for the min/max scanner family.
// Contents:
//   CMP_W          - widest data word the compare helper accepts
//   minmax_state_t - scanner FSM states
//   is_better()    - decides whether a new word replaces the held extreme
package minmax_pkg;

    localparam int unsigned CMP_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } minmax_state_t;

    // Callers must extend both operands to CMP_W first: sign-extend in signed
    // mode, zero-extend otherwise. Ties win only when tie_last is set.
    function automatic logic is_better(
        input logic [CMP_W-1:0] a,
        input logic [CMP_W-1:0] b,
        input logic             signed_cmp,
        input logic             find_max,
        input logic             tie_last
    );
        logic lt;
        logic eq;
        logic res;
        eq = (a == b);
        lt = signed_cmp ? ($signed(a) < $signed(b)) : (a < b);
        if (find_max) begin
            res = tie_last ? !lt : (!lt && !eq);
        end else begin
            res = tie_last ? (lt || eq) : lt;
        end
        return res;
    endfunction

endpackage

// File: rtl/minmax_scanner_if.sv
// Controller/memory-facing bundle of the min/max scanner.
// master: controller + data RAM side (drives Start, scan setup and Read_Data)
// slave : scanner side (drives memory strobe/address, status and results)
interface minmax_scanner_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) ();

    logic              Start;
    logic              Signed_Cmp;
    logic [ADDR_W-1:0] Base_Addr;
    logic [ADDR_W:0]   Length;
    logic              Mem_Rd_En;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Read_Data;
    logic              Busy;
    logic              Done;
    logic              Empty;
    logic [DATA_W-1:0] Result_Data;
    logic [ADDR_W-1:0] Result_Addr;

    modport master (
        output Start, Signed_Cmp, Base_Addr, Length, Read_Data,
        input  Mem_Rd_En, Mem_Addr, Busy, Done, Empty, Result_Data, Result_Addr
    );

    modport slave (
        input  Start, Signed_Cmp, Base_Addr, Length, Read_Data,
        output Mem_Rd_En, Mem_Addr, Busy, Done, Empty, Result_Data, Result_Addr
    );

endinterface

// File: rtl/minmax_scanner_cmp.sv
// Combinational extreme-value comparator (generalised single-word min compare).
// Ports:
//   New_Data    - incoming memory word
//   Held_Data   - currently held extreme
//   Signed_Cmp  - 1: two's-complement compare
//   Force_Load  - 1: first word of a scan, load unconditionally
//   Load_Result - 1: New_Data should replace Held_Data
module minmax_cmp #(
    parameter int unsigned DATA_W   = 16,
    parameter bit          FIND_MAX = 1'b0,
    parameter bit          TIE_LAST = 1'b0
) (
    input  logic [DATA_W-1:0] New_Data,
    input  logic [DATA_W-1:0] Held_Data,
    input  logic              Signed_Cmp,
    input  logic              Force_Load,
    output logic              Load_Result
);
    import minmax_pkg::*;

    logic [CMP_W-1:0] new_ext;
    logic [CMP_W-1:0] held_ext;

    // Extend to the helper's width so one function serves every DATA_W.
    always_comb begin
        if (Signed_Cmp) begin
            new_ext  = CMP_W'($signed(New_Data));
            held_ext = CMP_W'($signed(Held_Data));
        end else begin
            new_ext  = CMP_W'(New_Data);
            held_ext = CMP_W'(Held_Data);
        end
        Load_Result = Force_Load |
                      is_better(new_ext, held_ext, Signed_Cmp, FIND_MAX, TIE_LAST);
    end

endmodule

// File: rtl/minmax_scanner.sv
// Sequential min/max scanner: streams Length words from a synchronous-read
// RAM starting at Base_Addr and tracks the extreme value and its address.
// Ports:
//   Clk - rising-edge clock
//   Rst - synchronous active-high reset
//   bus - minmax_scanner_if.slave (start/setup, memory read port, status, results)
module minmax_scanner #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter bit          FIND_MAX = 1'b0,
    parameter bit          TIE_LAST = 1'b0
) (
    input  logic            Clk,
    input  logic            Rst,
    minmax_scanner_if.slave bus
);
    import minmax_pkg::*;

    localparam int unsigned LEN_W = ADDR_W + 1;

    minmax_state_t     state;
    minmax_state_t     next_state;
    logic [LEN_W-1:0]  remaining;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              first_pending;
    logic              signed_q;
    logic              last_read;
    logic              cmp_load;
    logic              load;
    logic              rd_en_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    assign last_read = (remaining == LEN_W'(1));
    assign load      = rd_valid & cmp_load;

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.Start) begin
                    next_state = (bus.Length == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (last_read) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output decode from next state, registered below so outputs track state
    always_comb begin
        rd_en_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (next_state)
            ST_READ: begin
                rd_en_nxt = 1'b1;
                busy_nxt  = 1'b1;
            end
            ST_DRAIN: busy_nxt = 1'b1;
            ST_DONE:  done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Registered control outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bus.Mem_Rd_En <= 1'b0;
            bus.Busy      <= 1'b0;
            bus.Done      <= 1'b0;
        end else begin
            bus.Mem_Rd_En <= rd_en_nxt;
            bus.Busy      <= busy_nxt;
            bus.Done      <= done_nxt;
        end
    end

    // Address/count counters, read-return tracking and result registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bus.Mem_Addr    <= '0;
            bus.Empty       <= 1'b0;
            bus.Result_Data <= '0;
            bus.Result_Addr <= '0;
            remaining       <= '0;
            rd_addr         <= '0;
            rd_valid        <= 1'b0;
            first_pending   <= 1'b0;
            signed_q        <= 1'b0;
        end else begin
            // Read data returns one cycle after the strobe; keep its address alongside.
            rd_valid <= bus.Mem_Rd_En;
            rd_addr  <= bus.Mem_Addr;

            if (load) begin
                bus.Result_Data <= bus.Read_Data;
                bus.Result_Addr <= rd_addr;
                first_pending   <= 1'b0;
            end

            if (state == ST_IDLE && bus.Start) begin
                if (bus.Length == '0) begin
                    bus.Empty <= 1'b1;
                end else begin
                    bus.Empty     <= 1'b0;
                    bus.Mem_Addr  <= bus.Base_Addr;
                    remaining     <= bus.Length;
                    signed_q      <= bus.Signed_Cmp;
                    first_pending <= 1'b1;
                end
            end else if (state == ST_READ && !last_read) begin
                // Wraps modulo 2^ADDR_W by construction.
                bus.Mem_Addr <= bus.Mem_Addr + ADDR_W'(1);
                remaining    <= remaining - LEN_W'(1);
            end
        end
    end

    minmax_cmp #(
        .DATA_W   (DATA_W),
        .FIND_MAX (FIND_MAX),
        .TIE_LAST (TIE_LAST)
    ) u_cmp (
        .New_Data    (bus.Read_Data),
        .Held_Data   (bus.Result_Data),
        .Signed_Cmp  (signed_q),
        .Force_Load  (first_pending),
        .Load_Result (cmp_load)
    );

endmodule

// File: tb/tb_minmax_scanner.sv
// Directed bench: three scanners (min/first, min/last, max/first) run in
// lockstep on a shared RAM image; expected values are hand-computed.
module tb_minmax_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       signed_cmp;
    logic [7:0] base;
    logic [8:0] length;

    logic [15:0] mem [0:255];
    logic [7:0]  addr_log [$];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cyc;
    int busy_cyc;
    int done_cnt;

    always #5 clk = ~clk;

    minmax_scanner_if #(.DATA_W(16), .ADDR_W(8)) u_if0 ();
    minmax_scanner_if #(.DATA_W(16), .ADDR_W(8)) u_if1 ();
    minmax_scanner_if #(.DATA_W(16), .ADDR_W(8)) u_if2 ();

    assign u_if0.Start = start;  assign u_if0.Signed_Cmp = signed_cmp;
    assign u_if0.Base_Addr = base; assign u_if0.Length = length;
    assign u_if1.Start = start;  assign u_if1.Signed_Cmp = signed_cmp;
    assign u_if1.Base_Addr = base; assign u_if1.Length = length;
    assign u_if2.Start = start;  assign u_if2.Signed_Cmp = signed_cmp;
    assign u_if2.Base_Addr = base; assign u_if2.Length = length;

    // Synchronous-read RAM model, one read port per scanner
    always @(posedge clk) begin
        if (u_if0.Mem_Rd_En) u_if0.Read_Data <= mem[u_if0.Mem_Addr];
        if (u_if1.Mem_Rd_En) u_if1.Read_Data <= mem[u_if1.Mem_Addr];
        if (u_if2.Mem_Rd_En) u_if2.Read_Data <= mem[u_if2.Mem_Addr];
    end

    minmax_scanner #(.DATA_W(16), .ADDR_W(8), .FIND_MAX(1'b0), .TIE_LAST(1'b0))
        u_dut0 (.Clk(clk), .Rst(rst), .bus(u_if0));
    minmax_scanner #(.DATA_W(16), .ADDR_W(8), .FIND_MAX(1'b0), .TIE_LAST(1'b1))
        u_dut1 (.Clk(clk), .Rst(rst), .bus(u_if1));
    minmax_scanner #(.DATA_W(16), .ADDR_W(8), .FIND_MAX(1'b1), .TIE_LAST(1'b0))
        u_dut2 (.Clk(clk), .Rst(rst), .bus(u_if2));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_res(input string tag,
                             input logic [15:0] d0, input logic [7:0] a0,
                             input logic [15:0] d1, input logic [7:0] a1,
                             input logic [15:0] d2, input logic [7:0] a2);
        check({tag, "_min_data"},  32'(u_if0.Result_Data), 32'(d0));
        check({tag, "_min_addr"},  32'(u_if0.Result_Addr), 32'(a0));
        check({tag, "_minl_data"}, 32'(u_if1.Result_Data), 32'(d1));
        check({tag, "_minl_addr"}, 32'(u_if1.Result_Addr), 32'(a1));
        check({tag, "_max_data"},  32'(u_if2.Result_Data), 32'(d2));
        check({tag, "_max_addr"},  32'(u_if2.Result_Addr), 32'(a2));
    endtask

    // Called at a negedge in IDLE; Start is high for the current cycle (cycle 0).
    // Returns at the negedge of the Done cycle (or after the cycle budget).
    task automatic run_scan(input logic s, input logic [7:0] b, input logic [8:0] l,
                            input int mid_cyc, input bit start_at_done,
                            output int dcyc, output int bcyc);
        int cyc;
        signed_cmp = s; base = b; length = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        dcyc  = -1;
        bcyc  = 0;
        addr_log.delete();
        while (dcyc < 0 && cyc < 40) begin
            if (u_if0.Busy) bcyc++;
            if (u_if0.Mem_Rd_En) addr_log.push_back(u_if0.Mem_Addr);
            if (u_if0.Done) begin
                dcyc = cyc;
                if (start_at_done) begin
                    start = 1'b1; base = 8'h00; length = 9'd3;
                end
            end else begin
                start = (cyc == mid_cyc);
                if (cyc == mid_cyc) begin
                    base = 8'h00; length = 9'd2; signed_cmp = ~s;
                end
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1234;
        mem[8'h10] = 16'd9;    mem[8'h11] = 16'd3;    mem[8'h12] = 16'd7;    mem[8'h13] = 16'd3;
        mem[8'h20] = 16'hFFFF; mem[8'h21] = 16'h8000; mem[8'h22] = 16'h0002; mem[8'h23] = 16'h7FFF;
        mem[8'hFE] = 16'h0050; mem[8'hFF] = 16'h0040; mem[8'h00] = 16'h0010; mem[8'h01] = 16'h0020;
        mem[8'h30] = 16'd5;
        mem[8'h40] = 16'd100;  mem[8'h41] = 16'd50;   mem[8'h42] = 16'd200;
        mem[8'h43] = 16'd50;   mem[8'h44] = 16'd25;   mem[8'h45] = 16'd300;
        for (int i = 0; i < 8; i++) mem[8'h50 + i] = 16'(i + 1);

        rst = 1'b1; start = 1'b0; signed_cmp = 1'b0; base = '0; length = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_rd_en", 32'(u_if0.Mem_Rd_En), 32'd0);
        check("rst_addr",  32'(u_if0.Mem_Addr),  32'd0);
        check("rst_busy",  32'(u_if0.Busy),      32'd0);
        check("rst_done",  32'(u_if0.Done),      32'd0);
        check("rst_empty", 32'(u_if0.Empty),     32'd0);
        check_res("rst", 16'd0, 8'd0, 16'd0, 8'd0, 16'd0, 8'd0);

        // Unsigned {9,3,7,3} at 0x10: tie policy picks 0x11 vs 0x13
        @(negedge clk);
        run_scan(1'b0, 8'h10, 9'd4, 0, 1'b0, done_cyc, busy_cyc);
        check("t1_done_cyc", 32'(done_cyc), 32'd6);
        check("t1_busy_cyc", 32'(busy_cyc), 32'd5);
        check("t1_empty",    32'(u_if0.Empty), 32'd0);
        check_res("t1", 16'd3, 8'h11, 16'd3, 8'h13, 16'd9, 8'h10);

        // Signed then unsigned on {FFFF,8000,0002,7FFF}
        @(negedge clk);
        run_scan(1'b1, 8'h20, 9'd4, 0, 1'b0, done_cyc, busy_cyc);
        check("t2s_done_cyc", 32'(done_cyc), 32'd6);
        check_res("t2s", 16'h8000, 8'h21, 16'h8000, 8'h21, 16'h7FFF, 8'h23);
        @(negedge clk);
        run_scan(1'b0, 8'h20, 9'd4, 0, 1'b0, done_cyc, busy_cyc);
        check_res("t2u", 16'h0002, 8'h22, 16'h0002, 8'h22, 16'hFFFF, 8'h20);

        // Address wrap from 0xFE
        @(negedge clk);
        run_scan(1'b0, 8'hFE, 9'd4, 0, 1'b0, done_cyc, busy_cyc);
        check("t3_nreads", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) begin
            check("t3_addr0", 32'(addr_log[0]), 32'hFE);
            check("t3_addr1", 32'(addr_log[1]), 32'hFF);
            check("t3_addr2", 32'(addr_log[2]), 32'h00);
            check("t3_addr3", 32'(addr_log[3]), 32'h01);
        end
        check_res("t3", 16'h0010, 8'h00, 16'h0010, 8'h00, 16'h0050, 8'hFE);

        // Length 0: immediate Done, Empty set, results held
        @(negedge clk);
        run_scan(1'b0, 8'h77, 9'd0, 0, 1'b0, done_cyc, busy_cyc);
        check("t4_done_cyc", 32'(done_cyc), 32'd1);
        check("t4_busy_cyc", 32'(busy_cyc), 32'd0);
        check("t4_empty0",   32'(u_if0.Empty), 32'd1);
        check("t4_empty2",   32'(u_if2.Empty), 32'd1);
        check_res("t4", 16'h0010, 8'h00, 16'h0010, 8'h00, 16'h0050, 8'hFE);
        @(negedge clk);
        run_scan(1'b0, 8'h30, 9'd1, 0, 1'b0, done_cyc, busy_cyc);
        check("t4b_done_cyc", 32'(done_cyc), 32'd3);
        check("t4b_empty",    32'(u_if0.Empty), 32'd0);
        check_res("t4b", 16'd5, 8'h30, 16'd5, 8'h30, 16'd5, 8'h30);

        // Start pulsed mid-scan and during Done: both ignored
        @(negedge clk);
        run_scan(1'b0, 8'h40, 9'd6, 2, 1'b1, done_cyc, busy_cyc);
        check("t5_done_cyc", 32'(done_cyc), 32'd8);
        check("t5_busy_cyc", 32'(busy_cyc), 32'd7);
        check_res("t5", 16'd25, 8'h44, 16'd25, 8'h44, 16'd300, 8'h45);
        @(negedge clk);
        start = 1'b0;
        check("t5_ign_busy",  32'(u_if0.Busy),      32'd0);
        check("t5_ign_rd_en", 32'(u_if0.Mem_Rd_En), 32'd0);
        check("t5_ign_done",  32'(u_if0.Done),      32'd0);
        // Start in the cycle right after Done is accepted
        run_scan(1'b0, 8'h40, 9'd2, 0, 1'b0, done_cyc, busy_cyc);
        check("t5b_done_cyc", 32'(done_cyc), 32'd4);
        check_res("t5b", 16'd50, 8'h41, 16'd50, 8'h41, 16'd100, 8'h40);

        // Reset in cycle 3 of an L=8 scan
        @(negedge clk);
        signed_cmp = 1'b0; base = 8'h50; length = 9'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rd_en", 32'(u_if0.Mem_Rd_En), 32'd0);
        check("t6_busy",  32'(u_if0.Busy),      32'd0);
        check_res("t6", 16'd0, 8'd0, 16'd0, 8'd0, 16'd0, 8'd0);
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (u_if0.Done || u_if2.Done) done_cnt++;
        end
        check("t6_no_done", 32'(done_cnt), 32'd0);
        run_scan(1'b0, 8'h50, 9'd8, 0, 1'b0, done_cyc, busy_cyc);
        check("t6b_done_cyc", 32'(done_cyc), 32'd10);
        check("t6b_busy_cyc", 32'(busy_cyc), 32'd9);
        check_res("t6b", 16'd1, 8'h50, 16'd1, 8'h50, 16'd8, 8'h57);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
